riscv_front_pipe: RTL and testbench

- Front three stages of the team's 5-stage RV32I pipeline: instruction fetch (IF), decode/register-file (ID) and execute (EX).
- Ends at the EX/MEM pipeline register, which feeds the memory stage.
- Accepts the branch redirect from the memory stage and the register write-back from the write-back stage.
- Accepts PC/IF-ID hold signals from hazard logic.

---
 rtl/riscv_front_pkg.sv | 54 +++++
 rtl/riscv_front_pipe_regfile.sv | 37 +++
 rtl/riscv_front_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_riscv_front_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_front_pkg.sv
// Shared constants, enums and the ALU-function decoder for the RV32I front pipeline.
package riscv_front_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Bit positions inside ex_ctrl / mem_ctrl / wb_ctrl
    localparam int EX_ALU_SRC    = 2;
    localparam int MEM_IS_BRANCH = 2;
    localparam int MEM_READ      = 1;
    localparam int MEM_WRITE     = 0;
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_fn_t;

    function automatic alu_fn_t aluFunc(input logic [1:0] aluOp, input logic [2:0] funct3,
                                        input logic funct7b5, input logic isRtype);
        alu_fn_t fn;
        fn = ALU_ADD;
        if (aluOp == ALUOP_SUB) begin
            fn = ALU_SUB;
        end else if (aluOp == ALUOP_FUNCT) begin
            case (funct3)
                3'b000:  fn = (isRtype && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  fn = ALU_SLL;
                3'b010:  fn = ALU_SLT;
                3'b011:  fn = ALU_SLTU;
                3'b100:  fn = ALU_XOR;
                3'b101:  fn = funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  fn = ALU_OR;
                default: fn = ALU_AND;
            endcase
        end
        return fn;
    endfunction

endpackage

// File: rtl/riscv_front_pipe_regfile.sv
// 32x32 register file: two combinational read ports with same-cycle write bypass, x0 reads zero.
module riscv_front_regfile
    import riscv_front_pkg::*;
(
    input  logic            clk,
    input  logic            wrEn,
    input  logic [4:0]      wrAddr,
    input  logic [XLEN-1:0] wrData,
    input  logic [4:0]      rdAddrA,
    input  logic [4:0]      rdAddrB,
    output logic [XLEN-1:0] rdDataA,
    output logic [XLEN-1:0] rdDataB
);

    logic [XLEN-1:0]            regs [32];
    logic [1:0][4:0]            rdAddr;
    logic [1:0][XLEN-1:0]       rdData;

    always_ff @(posedge clk) begin
        if (wrEn && wrAddr != 5'd0) begin
            regs[wrAddr] <= wrData;
        end
    end

    assign rdAddr[0] = rdAddrA;
    assign rdAddr[1] = rdAddrB;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        assign rdData[gi] = (rdAddr[gi] == 5'd0) ? '0 :
                            (wrEn && wrAddr == rdAddr[gi]) ? wrData :
                            regs[rdAddr[gi]];
    end

    assign rdDataA = rdData[0];
    assign rdDataB = rdData[1];

endmodule

// File: rtl/riscv_front_pipe.sv
// IF/ID/EX stages of the RV32I pipeline ending at the EX/MEM register.
// Define FORWARD_EN to enable EX-stage operand forwarding from EX/MEM and write-back.
module riscv_front_pipe
    import riscv_front_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch,
    input  logic [31:0] branch_addr,
    input  logic        pc_write,
    input  logic        ifid_write,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [4:0]  exmem_rd,
    output logic [31:0] exmem_alu,
    output logic [31:0] exmem_reg2,
    output logic        exmem_zero,
    output logic [31:0] exmem_branch_target,
    output logic [2:0]  exmem_mem_ctrl,
    output logic [1:0]  exmem_wb_ctrl
);

    logic [31:0] pcReg, pcNext;
    logic [31:0] ifidInstrReg, ifidPcReg;

    assign imem_addr = pcReg;

    always_comb begin
        pcNext = pcReg;
        if (branch)        pcNext = branch_addr;
        else if (pc_write) pcNext = pcReg + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (reset) pcReg <= RESET_PC;
        else       pcReg <= pcNext;
    end

    always_ff @(posedge clk) begin
        if (reset || branch) begin
            ifidInstrReg <= NOP_INSTR;
            ifidPcReg    <= '0;
        end else if (ifid_write) begin
            ifidInstrReg <= imem_rdata;
            ifidPcReg    <= pcReg;
        end
    end

    logic [6:0]  opcode;
    logic [31:0] iImm, sImm, bImm, immSel, rs1Val, rs2Val;
    logic [2:0]  exCtrl, memCtrl;
    logic [1:0]  wbCtrl;

    assign opcode = ifidInstrReg[6:0];
    assign iImm = {{20{ifidInstrReg[31]}}, ifidInstrReg[31:20]};
    assign sImm = {{20{ifidInstrReg[31]}}, ifidInstrReg[31:25], ifidInstrReg[11:7]};
    assign bImm = {{19{ifidInstrReg[31]}}, ifidInstrReg[31], ifidInstrReg[7],
                   ifidInstrReg[30:25], ifidInstrReg[11:8], 1'b0};

    always_comb begin
        exCtrl  = '0;
        memCtrl = '0;
        wbCtrl  = '0;
        immSel  = iImm;
        case (opcode)
            OPC_RTYPE: begin
                exCtrl = {1'b0, ALUOP_FUNCT};
                wbCtrl[WB_REG_WRITE] = 1'b1;
            end
            OPC_IALU: begin
                exCtrl = {1'b1, ALUOP_FUNCT};
                wbCtrl[WB_REG_WRITE] = 1'b1;
            end
            OPC_LOAD: begin
                exCtrl = {1'b1, ALUOP_ADD};
                memCtrl[MEM_READ]     = 1'b1;
                wbCtrl[WB_REG_WRITE]  = 1'b1;
                wbCtrl[WB_MEM_TO_REG] = 1'b1;
            end
            OPC_STORE: begin
                exCtrl = {1'b1, ALUOP_ADD};
                memCtrl[MEM_WRITE] = 1'b1;
                immSel = sImm;
            end
            OPC_BRANCH: begin
                exCtrl = {1'b0, ALUOP_SUB};
                memCtrl[MEM_IS_BRANCH] = 1'b1;
                immSel = bImm;
            end
            default: ;
        endcase
    end

    riscv_front_regfile u_regfile (
        .clk     (clk),
        .wrEn    (wb_reg_write),
        .wrAddr  (wb_rd),
        .wrData  (wb_data),
        .rdAddrA (ifidInstrReg[19:15]),
        .rdAddrB (ifidInstrReg[24:20]),
        .rdDataA (rs1Val),
        .rdDataB (rs2Val)
    );

    logic [31:0] idexPcReg, idexRs1ValReg, idexRs2ValReg, idexImmReg, idexBImmReg;
    logic [4:0]  idexRdReg;
    logic [2:0]  idexFunct3Reg, idexExReg, idexMemReg;
    logic [1:0]  idexWbReg;
    logic        idexFunct7b5Reg, idexIsRtypeReg;
`ifdef FORWARD_EN
    logic [4:0]  idexRs1Reg, idexRs2Reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            idexPcReg       <= '0;
            idexRs1ValReg   <= '0;
            idexRs2ValReg   <= '0;
            idexImmReg      <= '0;
            idexBImmReg     <= '0;
            idexRdReg       <= '0;
            idexFunct3Reg   <= '0;
            idexFunct7b5Reg <= 1'b0;
            idexIsRtypeReg  <= 1'b0;
            idexExReg       <= '0;
            idexMemReg      <= '0;
            idexWbReg       <= '0;
`ifdef FORWARD_EN
            idexRs1Reg      <= '0;
            idexRs2Reg      <= '0;
`endif
        end else begin
            idexPcReg       <= ifidPcReg;
            idexRs1ValReg   <= rs1Val;
            idexRs2ValReg   <= rs2Val;
            idexImmReg      <= immSel;
            idexBImmReg     <= bImm;
            idexRdReg       <= ifidInstrReg[11:7];
            idexFunct3Reg   <= ifidInstrReg[14:12];
            idexFunct7b5Reg <= ifidInstrReg[30];
            idexIsRtypeReg  <= (opcode == OPC_RTYPE);
`ifdef FORWARD_EN
            idexRs1Reg      <= ifidInstrReg[19:15];
            idexRs2Reg      <= ifidInstrReg[24:20];
`endif
            // A redirect turns the instruction now entering EX into a bubble
            idexExReg       <= branch ? 3'b000 : exCtrl;
            idexMemReg      <= branch ? 3'b000 : memCtrl;
            idexWbReg       <= branch ? 2'b00  : wbCtrl;
        end
    end

    logic [31:0] opA, opB, aluB, aluResult;
    logic [4:0]  shamt;
    alu_fn_t     aluFnSel;

`ifdef FORWARD_EN
    // Loads are excluded from EX/MEM forwarding: their data is not known until MEM.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] idexVal);
        if (exmem_wb_ctrl[WB_REG_WRITE] && !exmem_wb_ctrl[WB_MEM_TO_REG] &&
            exmem_rd != 5'd0 && exmem_rd == src)
            return exmem_alu;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == src)
            return wb_data;
        else
            return idexVal;
    endfunction

    assign opA = fwd(idexRs1Reg, idexRs1ValReg);
    assign opB = fwd(idexRs2Reg, idexRs2ValReg);
`else
    assign opA = idexRs1ValReg;
    assign opB = idexRs2ValReg;
`endif

    assign aluB     = idexExReg[EX_ALU_SRC] ? idexImmReg : opB;
    assign shamt    = aluB[4:0];
    assign aluFnSel = aluFunc(idexExReg[1:0], idexFunct3Reg, idexFunct7b5Reg, idexIsRtypeReg);

    always_comb begin
        case (aluFnSel)
            ALU_SUB:  aluResult = opA - aluB;
            ALU_SLL:  aluResult = opA << shamt;
            ALU_SLT:  aluResult = {31'b0, $signed(opA) < $signed(aluB)};
            ALU_SLTU: aluResult = {31'b0, opA < aluB};
            ALU_XOR:  aluResult = opA ^ aluB;
            ALU_SRL:  aluResult = opA >> shamt;
            ALU_SRA:  aluResult = 32'($signed(opA) >>> shamt);
            ALU_OR:   aluResult = opA | aluB;
            ALU_AND:  aluResult = opA & aluB;
            default:  aluResult = opA + aluB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exmem_rd            <= '0;
            exmem_alu           <= '0;
            exmem_reg2          <= '0;
            exmem_zero          <= 1'b0;
            exmem_branch_target <= '0;
            exmem_mem_ctrl      <= '0;
            exmem_wb_ctrl       <= '0;
        end else begin
            exmem_rd            <= idexRdReg;
            exmem_alu           <= aluResult;
            exmem_reg2          <= opB;
            exmem_zero          <= (aluResult == 32'd0);
            exmem_branch_target <= idexPcReg + idexBImmReg;
            exmem_mem_ctrl      <= idexMemReg;
            exmem_wb_ctrl       <= idexWbReg;
        end
    end

endmodule

// File: tb/tb_riscv_front_pipe.sv
// Self-checking bench for riscv_front_pipe: directed pipeline scenarios plus randomized single-issue instructions.
module tb_riscv_front_pipe;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [6:0]  OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011;
    localparam logic [6:0]  OP_S = 7'b0100011, OP_B = 7'b1100011, OP_LUI = 7'b0110111;

    logic        clk = 1'b0;
    logic        reset, branch, pc_write, ifid_write, wb_reg_write;
    logic [31:0] branch_addr, imem_addr, imem_rdata, wb_data;
    logic [4:0]  wb_rd;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_alu, exmem_reg2, exmem_branch_target;
    logic        exmem_zero;
    logic [2:0]  exmem_mem_ctrl;
    logic [1:0]  exmem_wb_ctrl;

    int checks = 0;
    int failures = 0;
    logic [31:0] modelPc, fetchPc;
    logic [31:0] rf [32];

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] reg2;
        logic        zero;
        logic [31:0] tgt;
        logic [2:0]  mem;
        logic [1:0]  wb;
    } exp_t;

    riscv_front_pipe #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .branch(branch), .branch_addr(branch_addr),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .exmem_rd(exmem_rd), .exmem_alu(exmem_alu), .exmem_reg2(exmem_reg2),
        .exmem_zero(exmem_zero), .exmem_branch_target(exmem_branch_target),
        .exmem_mem_ctrl(exmem_mem_ctrl), .exmem_wb_ctrl(exmem_wb_ctrl)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] iType(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] sType(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
    endfunction

    function automatic logic [31:0] bType(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_B};
    endfunction

    // Architectural result of an ALU-class operation from funct3 semantics
    function automatic logic [31:0] aluRef(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                                           input logic alt, input logic isR);
        case (f3)
            3'd0:    return (isR && alt) ? x - y : x + y;
            3'd1:    return x << y[4:0];
            3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3:    return (x < y) ? 32'd1 : 32'd0;
            3'd4:    return x ^ y;
            3'd5:    return alt ? 32'($signed(x) >>> y[4:0]) : (x >> y[4:0]);
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [31:0] a, b, iImm, sImm, bImm;
        a    = rf[ins[19:15]];
        b    = rf[ins[24:20]];
        iImm = {{20{ins[31]}}, ins[31:20]};
        sImm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        bImm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e.rd   = ins[11:7];
        e.reg2 = b;
        e.tgt  = pc + bImm;
        case (ins[6:0])
            OP_R:    begin e.mem = 3'b000; e.wb = 2'b10; e.alu = aluRef(ins[14:12], a, b, ins[30], 1'b1); end
            OP_I:    begin e.mem = 3'b000; e.wb = 2'b10; e.alu = aluRef(ins[14:12], a, iImm, ins[30], 1'b0); end
            OP_L:    begin e.mem = 3'b010; e.wb = 2'b11; e.alu = a + iImm; end
            OP_S:    begin e.mem = 3'b001; e.wb = 2'b00; e.alu = a + sImm; end
            OP_B:    begin e.mem = 3'b100; e.wb = 2'b00; e.alu = a - b; end
            default: begin e.mem = 3'b000; e.wb = 2'b00; e.alu = a + b; end
        endcase
        e.zero = (e.alu == 32'd0);
        return e;
    endfunction

    task automatic step();
        fetchPc = modelPc;
        @(posedge clk);
        if (reset)         modelPc = RST_PC;
        else if (branch)   modelPc = branch_addr;
        else if (pc_write) modelPc = modelPc + 32'd4;
        #1;
    endtask

    task automatic writeReg(input logic [4:0] r, input logic [31:0] v);
        wb_reg_write = 1'b1; wb_rd = r; wb_data = v;
        step();
        wb_reg_write = 1'b0;
        if (r != 5'd0) rf[r] = v;
    endtask

    // Fetch one instruction, then NOPs until it sits in EX/MEM
    task automatic issue(input logic [31:0] ins, output logic [31:0] pcOut);
        imem_rdata = ins;
        step();
        pcOut = fetchPc;
        imem_rdata = NOP;
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++; if (imem_addr !== RST_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", imem_addr, RST_PC); end
        checks++; if ({exmem_rd, exmem_alu, exmem_reg2, exmem_zero, exmem_branch_target, exmem_mem_ctrl, exmem_wb_ctrl} !== '0) begin
            failures++; $display("FAIL reset_exmem rd=%h alu=%h wb=%b mem=%b", exmem_rd, exmem_alu, exmem_wb_ctrl, exmem_mem_ctrl); end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (imem_addr !== RST_PC + 32'(4 * i)) begin failures++; $display("FAIL run_pc%0d got=%h exp=%h", i, imem_addr, RST_PC + 32'(4 * i)); end
            if (i == 1) begin
                checks++; if (exmem_wb_ctrl !== 2'b00) begin failures++; $display("FAIL idex_reset_bubble got=%b exp=00", exmem_wb_ctrl); end
            end
        end
        checks++; if (exmem_wb_ctrl !== 2'b10 || exmem_rd !== 5'd0 || exmem_alu !== 32'd0 || exmem_mem_ctrl !== 3'b000) begin
            failures++; $display("FAIL nop_exmem got wb=%b rd=%0d alu=%h mem=%b exp wb=10 rd=0 alu=0 mem=000",
                                 exmem_wb_ctrl, exmem_rd, exmem_alu, exmem_mem_ctrl); end
        $display("txn reset: pc=%h wb=%b", imem_addr, exmem_wb_ctrl);
    endtask

    task automatic test_alu();
        logic [31:0] p;
        writeReg(5'd1, 32'd5);
        writeReg(5'd2, 32'd7);
        issue(rType(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), p);
        checks++; if (exmem_alu !== 32'd12 || exmem_rd !== 5'd3 || exmem_wb_ctrl !== 2'b10) begin
            failures++; $display("FAIL add got alu=%h rd=%0d wb=%b exp alu=0000000c rd=3 wb=10", exmem_alu, exmem_rd, exmem_wb_ctrl); end
        issue(rType(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), p);
        checks++; if (exmem_alu !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub got=%h exp=fffffffe", exmem_alu); end
        $display("txn add/sub: last alu=%h", exmem_alu);
    endtask

    task automatic test_branch();
        logic [31:0] p;
        branch = 1'b1; branch_addr = 32'h20;
        step();
        branch = 1'b0;
        issue(bType(13'd16, 5'd1, 5'd1, 3'd0), p);
        checks++; if (exmem_zero !== 1'b1 || exmem_mem_ctrl !== 3'b100 || exmem_branch_target !== 32'h30) begin
            failures++; $display("FAIL beq got zero=%b mem=%b tgt=%h exp zero=1 mem=100 tgt=00000030",
                                 exmem_zero, exmem_mem_ctrl, exmem_branch_target); end
        $display("txn beq: pc=%h tgt=%h", p, exmem_branch_target);
    endtask

    task automatic test_mem();
        logic [31:0] p;
        issue(sType(12'd8, 5'd2, 5'd1, 3'b010), p);
        checks++; if (exmem_alu !== 32'd13 || exmem_reg2 !== 32'd7 || exmem_mem_ctrl !== 3'b001) begin
            failures++; $display("FAIL sw got alu=%h reg2=%h mem=%b exp alu=0000000d reg2=00000007 mem=001",
                                 exmem_alu, exmem_reg2, exmem_mem_ctrl); end
        issue(iType(12'd4, 5'd1, 3'b010, 5'd4, OP_L), p);
        checks++; if (exmem_mem_ctrl !== 3'b010 || exmem_wb_ctrl !== 2'b11 || exmem_alu !== 32'd9) begin
            failures++; $display("FAIL lw got mem=%b wb=%b alu=%h exp mem=010 wb=11 alu=00000009",
                                 exmem_mem_ctrl, exmem_wb_ctrl, exmem_alu); end
        $display("txn sw/lw: alu=%h", exmem_alu);
    endtask

    task automatic test_stall_flush();
        logic [31:0] heldPc;
        imem_rdata = iType(12'd3, 5'd0, 3'd0, 5'd7, OP_I);
        step();
        heldPc = modelPc;
        pc_write = 1'b0; ifid_write = 1'b0;
        imem_rdata = iType(12'd4, 5'd0, 3'd0, 5'd8, OP_I);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (imem_addr !== heldPc) begin failures++; $display("FAIL stall_pc%0d got=%h exp=%h", i, imem_addr, heldPc); end
        end
        checks++; if (exmem_rd !== 5'd7 || exmem_alu !== 32'd3) begin
            failures++; $display("FAIL stall_ex got rd=%0d alu=%h exp rd=7 alu=00000003", exmem_rd, exmem_alu); end
        // Redirect while still stalled: the redirect must win
        branch = 1'b1; branch_addr = 32'h40;
        imem_rdata = iType(12'd5, 5'd0, 3'd0, 5'd9, OP_I);
        step();
        branch = 1'b0; pc_write = 1'b1; ifid_write = 1'b1; imem_rdata = NOP;
        checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL redirect_pc got=%h exp=00000040", imem_addr); end
        checks++; if (exmem_rd !== 5'd7) begin failures++; $display("FAIL ifid_hold got rd=%0d exp=7", exmem_rd); end
        step();
        checks++; if (exmem_wb_ctrl !== 2'b00 || exmem_mem_ctrl !== 3'b000) begin
            failures++; $display("FAIL idex_bubble got wb=%b mem=%b exp wb=00 mem=000", exmem_wb_ctrl, exmem_mem_ctrl); end
        step();
        checks++; if (exmem_wb_ctrl !== 2'b10 || exmem_rd !== 5'd0 || imem_addr !== 32'h48) begin
            failures++; $display("FAIL ifid_flush got wb=%b rd=%0d pc=%h exp wb=10 rd=0 pc=00000048",
                                 exmem_wb_ctrl, exmem_rd, imem_addr); end
        $display("txn stall/flush: pc=%h", imem_addr);
    endtask

    task automatic test_forward();
        logic [31:0] expAlu;
`ifdef FORWARD_EN
        expAlu = 32'd10;
`else
        expAlu = 32'd1;
`endif
        writeReg(5'd5, 32'd0);
        imem_rdata = iType(12'd9, 5'd0, 3'd0, 5'd5, OP_I);
        step();
        imem_rdata = iType(12'd1, 5'd5, 3'd0, 5'd6, OP_I);
        step();
        imem_rdata = NOP;
        step();
        checks++; if (exmem_alu !== 32'd9 || exmem_rd !== 5'd5) begin
            failures++; $display("FAIL fwd_first got alu=%h rd=%0d exp alu=00000009 rd=5", exmem_alu, exmem_rd); end
        step();
        checks++; if (exmem_alu !== expAlu) begin failures++; $display("FAIL fwd_second got=%h exp=%h", exmem_alu, expAlu); end
        $display("txn dependent addi: alu=%h", exmem_alu);
    endtask

    task automatic test_bypass();
        imem_rdata = rType(7'h00, 5'd2, 5'd1, 3'd0, 5'd10);
        step();
        imem_rdata = NOP;
        wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 32'd100;
        step();
        wb_reg_write = 1'b0;
        rf[1] = 32'd100;
        step();
        checks++; if (exmem_alu !== 32'd107) begin failures++; $display("FAIL rf_bypass got=%h exp=0000006b", exmem_alu); end
        $display("txn bypass: alu=%h", exmem_alu);
    endtask

    task automatic test_random();
        logic [31:0] r, ins, p;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [11:0] imm;
        exp_t e;
        for (int i = 1; i < 32; i++) writeReg(5'(i), $urandom);
        for (int t = 0; t < 40; t++) begin
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            rd  = 5'($urandom_range(0, 31));
            f3  = 3'($urandom_range(0, 7));
            r   = $urandom;
            imm = r[31:20];
            if (rs1 != 5'd0) writeReg(rs1, $urandom);
            if (rs2 != 5'd0) writeReg(rs2, $urandom);
            if ($urandom_range(0, 3) == 0) writeReg(5'd0, $urandom);
            case ($urandom_range(0, 5))
                0: ins = rType(((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
                1: begin
                    if (f3 == 3'd1) imm[11:5] = 7'h00;
                    if (f3 == 3'd5) imm[11:5] = r[1] ? 7'h20 : 7'h00;
                    ins = iType(imm, rs1, f3, rd, OP_I);
                end
                2: ins = iType(imm, rs1, 3'b010, rd, OP_L);
                3: ins = sType(imm, rs2, rs1, 3'b010);
                4: ins = bType({r[31:20], 1'b0}, rs2, rs1, f3);
                default: ins = {r[31:12], rd, OP_LUI};
            endcase
            issue(ins, p);
            e = model(ins, p);
            checks++; if (exmem_rd !== e.rd) begin failures++; $display("FAIL rand%0d.rd ins=%h got=%0d exp=%0d", t, ins, exmem_rd, e.rd); end
            checks++; if (exmem_alu !== e.alu) begin failures++; $display("FAIL rand%0d.alu ins=%h got=%h exp=%h", t, ins, exmem_alu, e.alu); end
            checks++; if (exmem_reg2 !== e.reg2) begin failures++; $display("FAIL rand%0d.reg2 ins=%h got=%h exp=%h", t, ins, exmem_reg2, e.reg2); end
            checks++; if (exmem_zero !== e.zero) begin failures++; $display("FAIL rand%0d.zero ins=%h got=%b exp=%b", t, ins, exmem_zero, e.zero); end
            checks++; if (exmem_branch_target !== e.tgt) begin failures++; $display("FAIL rand%0d.tgt ins=%h got=%h exp=%h", t, ins, exmem_branch_target, e.tgt); end
            checks++; if (exmem_mem_ctrl !== e.mem) begin failures++; $display("FAIL rand%0d.mem ins=%h got=%b exp=%b", t, ins, exmem_mem_ctrl, e.mem); end
            checks++; if (exmem_wb_ctrl !== e.wb) begin failures++; $display("FAIL rand%0d.wb ins=%h got=%b exp=%b", t, ins, exmem_wb_ctrl, e.wb); end
            $display("txn rand%0d: ins=%h pc=%h alu=%h", t, ins, p, exmem_alu);
        end
    endtask

    initial begin
        reset = 1'b1; branch = 1'b0; branch_addr = '0;
        pc_write = 1'b1; ifid_write = 1'b1;
        imem_rdata = NOP;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        modelPc = '0; fetchPc = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_stall_flush();
        test_forward();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
